fibo_bcd_converter: RTL and testbench
=====================================

# fibo_bcd_converter

Sequential binary-to-BCD stage sitting directly downstream of the Fibonacci calculator. It captures each 16-bit result on the calculator's one-cycle `done` pulse, runs a 16-iteration shift-and-add-3 (double-dabble) conversion, and presents five BCD digits to a display/reporting consumer over a valid/ready handshake. A one-entry pending buffer absorbs a result that arrives while a conversion or hand-off is still in progress.

## Interface
Parameters: none (widths fixed: 16-bit binary in, 5 BCD digits out).

Ports:
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `fibo_in`  in  16  binary result from calculator; sampled only when `done_in`=1
- `done_in`  in  1  one-cycle result-valid pulse from calculator
- `bcd_out`  out  20  digits {d4,d3,d2,d1,d0}, d0 = ones in [3:0]; registered
- `bcd_valid`  out  1  `bcd_out` holds a completed conversion
- `bcd_ready`  in  1  consumer accepts `bcd_out` at an edge where `bcd_valid`=1
- `busy`  out  1  1 whenever state ≠ IDLE
- `overrun`  out  1  one-cycle pulse: a result was dropped

## Operation
- States: IDLE, SHIFT, HOLD. Internals: 16-bit shift reg `bin`, 20-bit `bcd_acc`, 4-bit iteration counter, pending reg + `pend_v`.
- IDLE: `done_in`=1 → `bin`←`fibo_in`, `bcd_acc`←0, count←0, →SHIFT. Otherwise stay.
- SHIFT, per cycle: each digit of `bcd_acc` ≥5 gets +3 (4-bit add, no carry between digits), then {`bcd_acc`,`bin`} shifted left 1. Count 15 iteration → `bcd_out`←result, `bcd_valid`←1, →HOLD.
- HOLD: `bcd_out` stable. On `bcd_valid`&&`bcd_ready`: `bcd_valid`←0; if `pend_v` → load pending into `bin`, clear `bcd_acc`/count, `pend_v`←0, →SHIFT; else →IDLE.
- `done_in` while in SHIFT or HOLD: `pend_v`=0 → pending←`fibo_in`, `pend_v`←1. `pend_v`=1 → value dropped, `overrun` pulses 1 cycle.
- Simultaneous HOLD hand-off consuming pending + `done_in`: new value stored into pending (`pend_v` stays 1), no overrun.
- IDLE never has `pend_v`=1.
- Full input range 0..65535 converts exactly; max 65535 → 0x65535.

## Timing
- Reset (async assert, any state, mid-conversion included): state IDLE, `bcd_out`=0, `bcd_valid`=0, `busy`=0, `overrun`=0, `pend_v`=0; in-flight and pending data discarded.
- Latency: capture edge E0; `bcd_valid` rises after edge E16 (16 cycles). Back-to-back from pending: 16 cycles after the accepting edge.
- `busy` rises after E0, falls after the accepting edge that returns to IDLE.
- `bcd_valid` held until accepted; `bcd_ready` ignored when `bcd_valid`=0.
- Throughput with `bcd_ready` tied high: one result per 17 cycles.

## Configuration
- `FIBO_BCD_BLANK_EN` defined: leading-zero blanking on `bcd_out`. Every digit above the most-significant nonzero digit is forced to 4'hF; d0 is never blanked (value 0 → 0xFFFF0). Applied when loading `bcd_out`; latency unchanged.
- Undefined: all five digits output raw (value 0 → 0x00000).

## Test plan
- Reset then `fibo_in`=46368 with a `done_in` pulse, `bcd_ready`=1 → `bcd_valid` after exactly 16 cycles, `bcd_out`=0x46368, `busy` drops the cycle after acceptance.
- Boundary values 0, 9, 10, 65535 → 0x00000, 0x00009, 0x00010, 0x65535; with `FIBO_BCD_BLANK_EN`: 0xFFFF0, 0xFFFF9, 0xFFF10, 0x65535.
- `bcd_ready`=0 for 10 cycles after valid → `bcd_out`/`bcd_valid` stable throughout; accepted on first ready edge, then →IDLE.
- 55 sent; 89 sent mid-SHIFT; 144 sent in HOLD → 89 pending, 144 dropped with one `overrun` pulse; outputs 0x00055 then 0x00089.
- `done_in`(233) on the same edge HOLD accepts with pending (89) → no overrun; outputs 0x00089 then 0x00233.
- Assert `reset_n` at iteration 8 with pending full → all outputs 0 immediately; the next `done_in`(377) converts cleanly to 0x00377.

Source files
------------

// File: rtl/fibo_bcd_converter.sv
// ---------------------------------------------------------------------------
// fibo_bcd_converter
//
// Converts each 16-bit result from the Fibonacci calculator into five BCD
// digits. It uses a 16-iteration shift-and-add-3 (double-dabble) sequence
// and hands each result to a display consumer over valid/ready. A one-entry
// pending buffer holds a result that arrives while the previous one is still
// being converted or waiting to be accepted. If a result arrives while that
// buffer is already full, it is dropped and flagged.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   fibo_in    16-bit binary result, sampled only when done_in = 1
//   done_in    one-cycle result-valid pulse from the calculator
//   bcd_out    registered digits {d4,d3,d2,d1,d0}, d0 (ones) in [3:0]
//   bcd_valid  bcd_out holds a completed conversion
//   bcd_ready  consumer takes bcd_out at an edge where bcd_valid = 1
//   busy       high whenever the converter is not idle
//   overrun    one-cycle pulse: an incoming result was dropped
//
// Build option:
//   FIBO_BCD_BLANK_EN  when defined, each digit above the most-significant
//                      nonzero digit is output as 4'hF. The ones digit is
//                      never blanked.
// ---------------------------------------------------------------------------
module fibo_bcd_converter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] fibo_in,
    input  logic        done_in,
    output logic [19:0] bcd_out,
    output logic        bcd_valid,
    input  logic        bcd_ready,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] bin_q, bin_d;
    logic [19:0] acc_q, acc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] pend_q, pend_d;
    logic        pend_v_q, pend_v_d;
    logic [19:0] bcd_out_q, bcd_out_d;
    logic        bcd_valid_q, bcd_valid_d;
    logic        overrun_q, overrun_d;

    logic [19:0] acc_adj;
    logic [19:0] acc_shift;
    logic        accept;

    // Add 3 to every digit that is 5 or more. Each digit is handled as its
    // own 4-bit value, so nothing carries from one digit into the next.
    function automatic logic [19:0] add3(input logic [19:0] a);
        logic [19:0] r;
        r = a;
        for (int i = 0; i < 5; i++) begin
            if (a[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = a[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Final digit formatting applied when loading bcd_out.
    function automatic logic [19:0] fmt(input logic [19:0] a);
        logic [19:0] r;
        r = a;
`ifdef FIBO_BCD_BLANK_EN
        begin
            logic lead;
            lead = 1'b1;
            // Walk from d4 down to d1. Digits stay blanked until the first
            // nonzero digit is found.
            for (int i = 4; i >= 1; i--) begin
                if (a[4*i +: 4] != 4'd0)
                    lead = 1'b0;
                if (lead)
                    r[4*i +: 4] = 4'hF;
            end
        end
`endif
        return r;
    endfunction

    assign acc_adj   = add3(acc_q);
    // One double-dabble step: shift {acc, bin} left by one bit. The adjusted
    // top bit can be dropped because 65535 fits in five digits.
    assign acc_shift = {acc_adj[18:0], bin_q[15]};
    assign accept    = bcd_valid_q && bcd_ready;

    // NOTE: every variable is given its hold value first, so no path through
    // the case statement leaves one unassigned (no latches are inferred).
    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        pend_v_d    = pend_v_q;
        bcd_out_d   = bcd_out_q;
        bcd_valid_d = bcd_valid_q;
        overrun_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (done_in) begin
                    bin_d   = fibo_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end

            S_SHIFT: begin
                acc_d = acc_shift;
                bin_d = {bin_q[14:0], 1'b0};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    bcd_out_d   = fmt(acc_shift);
                    bcd_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end
                if (done_in) begin
                    if (!pend_v_q) begin
                        pend_d   = fibo_in;
                        pend_v_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end

            S_HOLD: begin
                if (accept) begin
                    bcd_valid_d = 1'b0;
                    if (pend_v_q) begin
                        bin_d   = pend_q;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = S_SHIFT;
                        // The pending slot empties on this edge, so a new
                        // arrival takes it straight away and nothing is lost.
                        if (done_in)
                            pend_d = fibo_in;
                        else
                            pend_v_d = 1'b0;
                    end else if (done_in) begin
                        // Nothing is waiting, so start on the new arrival at
                        // once. Going idle here would lose it, because idle
                        // never keeps a pending entry.
                        bin_d   = fibo_in;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = S_SHIFT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (done_in) begin
                    if (!pend_v_q) begin
                        pend_d   = fibo_in;
                        pend_v_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register updates from values sampled before the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            bin_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            pend_q      <= '0;
            pend_v_q    <= 1'b0;
            bcd_out_q   <= '0;
            bcd_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            pend_v_q    <= pend_v_d;
            bcd_out_q   <= bcd_out_d;
            bcd_valid_q <= bcd_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bcd_out   = bcd_out_q;
    assign bcd_valid = bcd_valid_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_fibo_bcd_converter.sv
`timescale 1ns/1ps
module tb_fibo_bcd_converter;

    logic        clk       = 1'b0;
    logic        reset_n   = 1'b0;
    logic [15:0] fibo_in   = '0;
    logic        done_in   = 1'b0;
    logic        bcd_ready = 1'b0;
    logic [19:0] bcd_out;
    logic        bcd_valid;
    logic        busy;
    logic        overrun;

    always #5 clk = ~clk;

    fibo_bcd_converter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .fibo_in   (fibo_in),
        .done_in   (done_in),
        .bcd_out   (bcd_out),
        .bcd_valid (bcd_valid),
        .bcd_ready (bcd_ready),
        .busy      (busy),
        .overrun   (overrun)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%05h, expected 0x%05h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference conversion: decimal digits from integer arithmetic, with
    // optional leading-zero blanking.
    function automatic logic [19:0] to_bcd(input int unsigned v);
        logic [19:0] r;
        int unsigned t;
        int          msd;
        r   = '0;
        t   = v;
        msd = 0;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            if ((t % 10) != 0) msd = i;
            t = t / 10;
        end
`ifdef FIBO_BCD_BLANK_EN
        for (int i = 1; i < 5; i++)
            if (i > msd) r[4*i +: 4] = 4'hF;
`endif
        return r;
    endfunction

    // Transaction-level model. mq holds the results the converter owns: the
    // head is being converted or held, and a second entry is pending. The head
    // becomes valid 16 edges after the edge that started it.
    int unsigned mq[$];
    int unsigned cyc       = 0;
    int unsigned start_cyc = 0;
    logic        exp_ovr   = 1'b0;
    logic        m_acc;

    function automatic logic m_valid();
        return (mq.size() > 0) && ((cyc - start_cyc) >= 16);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            cyc       = 0;
            start_cyc = 0;
            exp_ovr   = 1'b0;
        end else begin
            m_acc   = m_valid() && bcd_ready;
            cyc     = cyc + 1;
            exp_ovr = 1'b0;
            if (m_acc) begin
                void'(mq.pop_front());
                if (mq.size() > 0) start_cyc = cyc;
            end
            if (done_in) begin
                if (mq.size() == 0) begin
                    mq.push_back(int'(fibo_in));
                    start_cyc = cyc;
                end else if (mq.size() == 1) begin
                    mq.push_back(int'(fibo_in));
                end else begin
                    exp_ovr = 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (reset_n) begin
            check("cyc_valid",   bcd_valid, m_valid());
            check("cyc_busy",    busy,      mq.size() != 0);
            check("cyc_overrun", overrun,   exp_ovr);
            if (m_valid())
                check("cyc_bcd_out", bcd_out, to_bcd(mq[0]));
        end
    end

    // Log of results handed to the consumer, and the overrun pulse count.
    logic [19:0] acc_log[$];
    int          ovr_cnt = 0;

    always @(posedge clk)
        if (reset_n && bcd_valid && bcd_ready) acc_log.push_back(bcd_out);

    always @(negedge clk)
        if (reset_n && overrun) ovr_cnt++;

    function automatic logic [19:0] log_at(input int i);
        return (acc_log.size() > i) ? acc_log[i] : 20'hxxxxx;
    endfunction

    // Stimulus helpers. Inputs are always changed 1 ns after a rising edge.
    task automatic send(input logic [15:0] v);
        fibo_in = v;
        done_in = 1'b1;
        @(posedge clk); #1;
        done_in = 1'b0;
    endtask

    task automatic wait_valid(input int max, output int n);
        n = 0;
        while (!bcd_valid && n < max) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_valid", bcd_valid, 1'b1);
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while (busy && n < max) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_idle", busy, 1'b0);
    endtask

    // Expected literals for each build.
`ifdef FIBO_BCD_BLANK_EN
    localparam logic [19:0] L_0 = 20'hFFFF0, L_9 = 20'hFFFF9, L_10 = 20'hFFF10;
    localparam logic [19:0] L_55 = 20'hFFF55, L_89 = 20'hFFF89, L_144 = 20'hFF144;
    localparam logic [19:0] L_233 = 20'hFF233, L_377 = 20'hFF377, L_4181 = 20'hF4181;
`else
    localparam logic [19:0] L_0 = 20'h00000, L_9 = 20'h00009, L_10 = 20'h00010;
    localparam logic [19:0] L_55 = 20'h00055, L_89 = 20'h00089, L_144 = 20'h00144;
    localparam logic [19:0] L_233 = 20'h00233, L_377 = 20'h00377, L_4181 = 20'h04181;
`endif

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          n;
        logic [15:0] bvals[4];
        logic [19:0] bexp[4];
        bvals = '{16'd0, 16'd9, 16'd10, 16'd65535};
        bexp  = '{L_0, L_9, L_10, 20'h65535};

        // Tie the reference model to hand-computed values.
        check("model_46368", to_bcd(46368), 20'h46368);
        check("model_65535", to_bcd(65535), 20'h65535);
        check("model_0",     to_bcd(0),     L_0);
        check("model_10",    to_bcd(10),    L_10);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_bcd_out",   bcd_out,   20'h0);
        check("rst_bcd_valid", bcd_valid, 1'b0);
        check("rst_busy",      busy,      1'b0);
        check("rst_overrun",   overrun,   1'b0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Basic conversion: latency and the busy release.
        bcd_ready = 1'b1;
        send(16'd46368);
        check("busy_after_capture", busy, 1'b1);
        wait_valid(40, n);
        check("latency_16", 20'(n), 20'd16);
        check("out_46368",  bcd_out, 20'h46368);
        @(posedge clk); #1;
        check("busy_drop",  busy,      1'b0);
        check("valid_drop", bcd_valid, 1'b0);

        // Boundary values.
        for (int i = 0; i < 4; i++) begin
            send(bvals[i]);
            wait_valid(40, n);
            check("boundary_out", bcd_out, bexp[i]);
            @(posedge clk); #1;
            check("boundary_idle", busy, 1'b0);
        end

        // Back-pressure: the output holds steady while bcd_ready is low.
        bcd_ready = 1'b0;
        send(16'd4181);
        wait_valid(40, n);
        check("bp_out", bcd_out, L_4181);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_valid_hold", bcd_valid, 1'b1);
            check("bp_out_hold",   bcd_out,   L_4181);
        end
        bcd_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_accepted", bcd_valid, 1'b0);
        check("bp_idle",     busy,      1'b0);

        // Pending fill, then a dropped result.
        acc_log.delete();
        ovr_cnt   = 0;
        bcd_ready = 1'b0;
        send(16'd55);
        repeat (5) begin @(posedge clk); #1; end
        send(16'd89);
        wait_valid(40, n);
        send(16'd144);
        check("ovr_pulse_hi", overrun, 1'b1);
        @(posedge clk); #1;
        check("ovr_pulse_lo", overrun, 1'b0);
        bcd_ready = 1'b1;
        wait_idle(80);
        check("ovr_log_size", 20'(acc_log.size()), 20'd2);
        check("ovr_log0",     log_at(0), L_55);
        check("ovr_log1",     log_at(1), L_89);
        check("ovr_count",    20'(ovr_cnt), 20'd1);

        // A new result on the same edge that hands pending over: no overrun.
        acc_log.delete();
        ovr_cnt   = 0;
        bcd_ready = 1'b0;
        send(16'd144);
        repeat (5) begin @(posedge clk); #1; end
        send(16'd89);
        wait_valid(40, n);
        fibo_in   = 16'd233;
        done_in   = 1'b1;
        bcd_ready = 1'b1;
        @(posedge clk); #1;
        done_in = 1'b0;
        check("simul_no_ovr", overrun, 1'b0);
        wait_idle(80);
        check("simul_log_size", 20'(acc_log.size()), 20'd3);
        check("simul_log0",     log_at(0), L_144);
        check("simul_log1",     log_at(1), L_89);
        check("simul_log2",     log_at(2), L_233);
        check("simul_ovr_cnt",  20'(ovr_cnt), 20'd0);

        // Reset mid-conversion with the pending slot full.
        acc_log.delete();
        bcd_ready = 1'b0;
        send(16'd1000);
        repeat (2) begin @(posedge clk); #1; end
        send(16'd2000);
        repeat (5) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_bcd_out",   bcd_out,   20'h0);
        check("mid_rst_bcd_valid", bcd_valid, 1'b0);
        check("mid_rst_busy",      busy,      1'b0);
        check("mid_rst_overrun",   overrun,   1'b0);
        @(posedge clk); #1;
        reset_n   = 1'b1;
        bcd_ready = 1'b1;
        send(16'd377);
        wait_valid(40, n);
        check("post_rst_latency", 20'(n), 20'd16);
        check("post_rst_out",     bcd_out, L_377);
        wait_idle(40);
        check("post_rst_log_size", 20'(acc_log.size()), 20'd1);
        check("post_rst_log0",     log_at(0), L_377);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
